// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared widths, helpers and channel constants for the result demux
//
// Purpose: common definitions imported by the demux interface, FIFO and top.
// Contents: WORD_W (datapath word width), cnt_w() (occupancy counter width
// for a FIFO of a given depth), CH_OUT0/CH_OUT1 (select encodings).
package mips_pkg;

  localparam int WORD_W = 32;

  localparam logic CH_OUT0 = 1'b0;
  localparam logic CH_OUT1 = 1'b1;

  // Occupancy must represent 0..depth inclusive, hence one bit above the
  // pointer width.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/demux_1to2_buf_if.sv
// rtl/demux_1to2_buf_if.sv - producer stream plus two consumer streams of the 1:2 demux
//
// Purpose: bundles the producer-side and both consumer-side handshakes.
// Signals:
//   in_data/in_sel/in_valid/in_ready        producer word, destination, handshake
//   outN_data/outN_valid/outN_ready         consumer N head word and handshake
//   outN_count                              consumer N FIFO occupancy
// Modports: slave = the demux itself, master = the environment around it.
interface demux_1to2_buf_if
  import mips_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int DEPTH = 2
);

  localparam int CW = cnt_w(DEPTH);

  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             in_valid;
  logic             in_ready;

  logic [WIDTH-1:0] out0_data;
  logic             out0_valid;
  logic             out0_ready;
  logic [CW-1:0]    out0_count;

  logic [WIDTH-1:0] out1_data;
  logic             out1_valid;
  logic             out1_ready;
  logic [CW-1:0]    out1_count;

  modport slave (
    input  in_data, in_sel, in_valid, out0_ready, out1_ready,
    output in_ready, out0_data, out0_valid, out0_count,
           out1_data, out1_valid, out1_count
  );

  modport master (
    output in_data, in_sel, in_valid, out0_ready, out1_ready,
    input  in_ready, out0_data, out0_valid, out0_count,
           out1_data, out1_valid, out1_count
  );

endinterface

// File: rtl/demux_fifo.sv
// rtl/demux_fifo.sv - per-channel output FIFO of the 1:2 demux
//
// Purpose: DEPTH-entry registered FIFO, no fall-through.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   push, push_data write request (ignored when full) and word
//   full            count == DEPTH
//   pop             read request (ignored when empty)
//   head_data       head entry when valid, otherwise 0
//   valid           FIFO non-empty
//   count           occupancy 0..DEPTH
module demux_fifo
  import mips_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  output logic                     full,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     valid,
  output logic [cnt_w(DEPTH)-1:0]  count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  logic do_push;
  logic do_pop;

  assign full      = (count_q == CW'(DEPTH));
  assign valid     = (count_q != '0);
  assign count     = count_q;
  assign head_data = valid ? mem_q[rd_ptr_q] : '0;

  // Requests are re-qualified here so the FIFO cannot overflow or underflow
  // regardless of how the caller gates them.
  assign do_push = push & ~full;
  assign do_pop  = pop & valid;

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/demux_1to2_buf.sv
// rtl/demux_1to2_buf.sv - registered 1:2 demux with a FIFO per output channel
//
// Purpose: steers each producer word to out0 or out1 by in_sel; each channel
// buffers independently so consumers can stall without blocking each other.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset, empties both channels
//   bus   demux_1to2_buf_if.slave: producer stream in, two consumer streams out
module demux_1to2_buf
  import mips_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  demux_1to2_buf_if.slave   bus
);

  logic full0;
  logic full1;
  logic sel1;
  logic push0;
  logic push1;

  assign sel1 = (bus.in_sel == CH_OUT1);

  // in_ready looks only at the selected channel's registered fullness, so
  // consumer ready never reaches producer ready combinationally. A full
  // channel that pops this cycle still refuses the word until next cycle.
  assign bus.in_ready = sel1 ? ~full1 : ~full0;

  assign push0 = bus.in_valid & bus.in_ready & ~sel1;
  assign push1 = bus.in_valid & bus.in_ready &  sel1;

  demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
    .clk       (clk),
    .rst       (rst),
    .push      (push0),
    .push_data (bus.in_data),
    .full      (full0),
    .pop       (bus.out0_ready),
    .head_data (bus.out0_data),
    .valid     (bus.out0_valid),
    .count     (bus.out0_count)
  );

  demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
    .clk       (clk),
    .rst       (rst),
    .push      (push1),
    .push_data (bus.in_data),
    .full      (full1),
    .pop       (bus.out1_ready),
    .head_data (bus.out1_data),
    .valid     (bus.out1_valid),
    .count     (bus.out1_count)
  );

endmodule

// File: tb/tb_demux_1to2_buf.sv
// tb/tb_demux_1to2_buf.sv - self-checking bench for demux_1to2_buf
module tb_demux_1to2_buf;

  localparam int WIDTH = 32;
  localparam int DEPTH = 2;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  bit   cmp_en;

  logic [WIDTH-1:0] q0 [$];
  logic [WIDTH-1:0] q1 [$];
  logic [WIDTH-1:0] log0 [$];
  logic [WIDTH-1:0] log1 [$];

  demux_1to2_buf_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  demux_1to2_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Queue model: a channel accepts when it held fewer than DEPTH words before
  // the edge; pops take the front of a non-empty queue.
  initial begin
    bit push_ok;
    bit pop0;
    bit pop1;
    forever begin
      @(posedge clk);
      if (rst) begin
        q0.delete();
        q1.delete();
        cmp_en = 1'b1;
      end else begin
        push_ok = bus.in_valid && ((bus.in_sel ? q1.size() : q0.size()) < DEPTH);
        pop0    = bus.out0_ready && (q0.size() != 0);
        pop1    = bus.out1_ready && (q1.size() != 0);
        if (pop0) log0.push_back(q0.pop_front());
        if (pop1) log1.push_back(q1.pop_front());
        if (push_ok) begin
          if (bus.in_sel) q1.push_back(bus.in_data);
          else            q0.push_back(bus.in_data);
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        chk("in_ready", 64'(bus.in_ready),
            64'(((bus.in_sel ? q1.size() : q0.size()) < DEPTH)));
        chk("out0_count", 64'(bus.out0_count), 64'(q0.size()));
        chk("out1_count", 64'(bus.out1_count), 64'(q1.size()));
        chk("out0_valid", 64'(bus.out0_valid), 64'(q0.size() != 0));
        chk("out1_valid", 64'(bus.out1_valid), 64'(q1.size() != 0));
        chk("out0_data", 64'(bus.out0_data), 64'((q0.size() != 0) ? q0[0] : '0));
        chk("out1_data", 64'(bus.out1_data), 64'((q1.size() != 0) ? q1[0] : '0));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic [WIDTH-1:0] d);
    bus.in_valid = v;
    bus.in_sel   = s;
    bus.in_data  = d;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cmp_en = 1'b0;
    rst = 1'b1;
    drive(1'b1, 1'b0, 32'hDEAD_BEEF);
    bus.out0_ready = 1'b1;
    bus.out1_ready = 1'b1;

    // Reset held two edges with a valid word present.
    step();
    step();
    chk("rst_count0", 64'(bus.out0_count), 64'd0);
    chk("rst_valid0", 64'(bus.out0_valid), 64'd0);
    chk("rst_data0", 64'(bus.out0_data), 64'd0);
    chk("rst_valid1", 64'(bus.out1_valid), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    rst = 1'b0;
    drive(1'b0, 1'b0, '0);
    step();
    chk("post_rst_count0", 64'(bus.out0_count), 64'd0);
    chk("post_rst_count1", 64'(bus.out1_count), 64'd0);

    // Routing: 5 to ch0, then 9 to ch1, consumers ready.
    drive(1'b1, 1'b0, 32'd5);
    step();
    chk("route_data0", 64'(bus.out0_data), 64'd5);
    chk("route_valid0", 64'(bus.out0_valid), 64'd1);
    chk("route_valid1_early", 64'(bus.out1_valid), 64'd0);
    drive(1'b1, 1'b1, 32'd9);
    step();
    chk("route_data1", 64'(bus.out1_data), 64'd9);
    chk("route_valid0_gone", 64'(bus.out0_valid), 64'd0);
    drive(1'b0, 1'b0, '0);
    step();
    chk("route_count0", 64'(bus.out0_count), 64'd0);
    chk("route_count1", 64'(bus.out1_count), 64'd0);

    // Backpressure on ch0.
    bus.out0_ready = 1'b0;
    drive(1'b1, 1'b0, 32'd1);
    step();
    drive(1'b1, 1'b0, 32'd2);
    step();
    chk("bp_count0", 64'(bus.out0_count), 64'd2);
    drive(1'b1, 1'b0, 32'd99);
    #1;
    chk("bp_ready_sel0", 64'(bus.in_ready), 64'd0);
    drive(1'b1, 1'b1, 32'd7);
    #1;
    chk("bp_ready_sel1", 64'(bus.in_ready), 64'd1);
    step();
    chk("bp_data1", 64'(bus.out1_data), 64'd7);
    chk("bp_count0_hold", 64'(bus.out0_count), 64'd2);

    // Full plus pop: the word 3 waits one cycle.
    bus.out0_ready = 1'b1;
    drive(1'b1, 1'b0, 32'd3);
    #1;
    chk("fp_ready_full", 64'(bus.in_ready), 64'd0);
    step();
    chk("fp_count0", 64'(bus.out0_count), 64'd1);
    chk("fp_head0", 64'(bus.out0_data), 64'd2);
    chk("fp_ready_again", 64'(bus.in_ready), 64'd1);
    step();
    chk("fp_head3", 64'(bus.out0_data), 64'd3);
    drive(1'b0, 1'b0, '0);
    step();
    chk("fp_drained", 64'(bus.out0_count), 64'd0);

    // Simultaneous push and pop on ch1.
    bus.out1_ready = 1'b0;
    drive(1'b1, 1'b1, 32'd10);
    step();
    chk("pp_count1", 64'(bus.out1_count), 64'd1);
    chk("pp_head10", 64'(bus.out1_data), 64'd10);
    bus.out1_ready = 1'b1;
    drive(1'b1, 1'b1, 32'd11);
    step();
    chk("pp_count_same", 64'(bus.out1_count), 64'd1);
    chk("pp_head11", 64'(bus.out1_data), 64'd11);
    drive(1'b0, 1'b0, '0);
    step();

    // Mid-stream reset discards everything buffered.
    bus.out0_ready = 1'b0;
    bus.out1_ready = 1'b0;
    drive(1'b1, 1'b0, 32'hA0);
    step();
    drive(1'b1, 1'b0, 32'hA1);
    step();
    drive(1'b1, 1'b1, 32'hB0);
    step();
    drive(1'b1, 1'b1, 32'hB1);
    step();
    chk("mr_count0", 64'(bus.out0_count), 64'd2);
    chk("mr_count1", 64'(bus.out1_count), 64'd2);
    drive(1'b0, 1'b0, '0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mr_cleared0", 64'(bus.out0_count), 64'd0);
    chk("mr_cleared1", 64'(bus.out1_count), 64'd0);
    bus.out0_ready = 1'b1;
    bus.out1_ready = 1'b1;
    drive(1'b1, 1'b1, 32'd0);
    step();
    chk("mr_valid1", 64'(bus.out1_valid), 64'd1);
    drive(1'b0, 1'b0, '0);
    step();
    step();

    // Observed pop order per channel pins the model itself.
    chk("log0_size", 64'(log0.size()), 64'd4);
    if (log0.size() == 4) begin
      chk("log0_0", 64'(log0[0]), 64'd5);
      chk("log0_1", 64'(log0[1]), 64'd1);
      chk("log0_2", 64'(log0[2]), 64'd2);
      chk("log0_3", 64'(log0[3]), 64'd3);
    end
    chk("log1_size", 64'(log1.size()), 64'd5);
    if (log1.size() == 5) begin
      chk("log1_0", 64'(log1[0]), 64'd9);
      chk("log1_1", 64'(log1[1]), 64'd7);
      chk("log1_2", 64'(log1[2]), 64'd10);
      chk("log1_3", 64'(log1[3]), 64'd11);
      chk("log1_4", 64'(log1[4]), 64'd0);
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux_1to2_buf.md
Name: demux_1to2_buf

Overview:
- Registered 1-to-2 demultiplexer: the steering counterpart of the 2:1 datapath select. One 32-bit producer stream is routed to one of two consumer channels by a per-word select bit.
- Each output channel has its own small FIFO with valid/ready handshake, so the two destinations can stall independently.
- Sits between a result source (ALU or memory stage) and two consumers, e.g. writeback and forwarding/debug ports.

Parameters:
- WIDTH, 32, data word width in bits.
- DEPTH, 2, entries per output FIFO; power of two, minimum 2.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  word to route.
- in_sel  input  1  destination: 0 routes to out0, 1 routes to out1.
- in_valid  input  1  producer has a word.
- in_ready  output  1  selected channel can accept.
- out0_data  output  WIDTH  head word of channel 0.
- out0_valid  output  1  channel 0 non-empty.
- out0_ready  input  1  consumer 0 pops.
- out1_data  output  WIDTH  head word of channel 1.
- out1_valid  output  1  channel 1 non-empty.
- out1_ready  input  1  consumer 1 pops.
- out0_count  output  $clog2(DEPTH)+1  channel 0 occupancy.
- out1_count  output  $clog2(DEPTH)+1  channel 1 occupancy.

Behaviour:
- Reset, sampled on the clk edge while rst=1:
  - Both FIFOs emptied; rd/wr pointers = 0; counts = 0; outN_valid = 0; outN_data = 0.
  - Reset wins over any push or pop in the same cycle.
  - Reset mid-stream discards all buffered words.
- in_ready:
  - Combinational: equals ~full of the channel selected by in_sel, where full means count == DEPTH.
  - Depends only on registered state and in_sel, never on outN_ready. There is no ready-to-ready combinational path.
- Push:
  - Occurs when in_valid & in_ready at the edge.
  - Writes in_data at the wr pointer of the selected channel; that pointer advances and wraps modulo DEPTH.
  - The unselected channel is untouched.
- Pop:
  - Channel N pops when outN_valid & outN_ready at the edge; its rd pointer advances and wraps modulo DEPTH.
  - outN_ready while empty is ignored.
- Latency: a word pushed at edge k is visible on outN_data with outN_valid=1 after edge k (one cycle). There is no fall-through in the same cycle.
- outN_valid = (countN != 0), registered-state derived.
- outN_data = head entry when valid, else 0 (masked).
- Count update per channel:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged, and the head advances while the new word lands at the tail.
- Full channel with pop in the same cycle: in_ready is still 0 (full), so no push. The channel accepts again from the next cycle.
- Both channels can pop in the same cycle as a push into either one.
- Ordering: FIFO order is preserved per channel. There is no ordering guarantee between channels.
- Stalled input: if in_valid=1 and in_ready=0, the producer holds in_data/in_sel. The block makes no assumption about a select change while stalled; it evaluates each cycle afresh.
- Never drops or duplicates a word. Count never exceeds DEPTH or goes below 0 (assertions in the bench).

Decomposition:
- Shared package mips_pkg:
  - WORD_W = 32.
  - Function cnt_w(depth) = $clog2(depth)+1.
  - Channel index constants CH_OUT0 = 1'b0, CH_OUT1 = 1'b1.
- Sub-module demux_fifo (WIDTH, DEPTH):
  - Ports: clk, rst, push, push_data, full, pop, head_data, valid, count.
  - Instantiated twice.
- Top contains only select decode, push gating and in_ready mux (~60 lines); demux_fifo ~100 lines.

Test Plan:
- Reset: assert rst 2 cycles with in_valid=1 -> counts 0, both valids 0, data 0, in_ready=1; release -> no spurious words.
- Routing: push 32'd5 sel=0, then 32'd9 sel=1, both consumers ready -> out0 shows 5 and out1 shows 9, each exactly one cycle after its push; counts return to 0.
- Backpressure: out0_ready=0, push 32'd1, 32'd2 to ch0 -> out0_count=2 and in_ready=0 for sel=0. With sel=1, in_ready=1 and a push of 32'd7 reaches out1.
- Full plus pop: ch0 full, out0_ready=1, in_valid=1 sel=0 data 32'd3 -> that cycle no push (in_ready=0). Next cycle the push is accepted; drain order is 2, 3.
- Simultaneous push/pop: ch1 count=1 (32'd10), push 32'd11 with out1_ready=1 -> count stays 1, head becomes 11.
- Reset mid-operation: both channels hold 2 words, pulse rst 1 cycle -> all counts 0; the next push of 32'd0 to ch1 is the only word observed.
